data_mem_responder: RTL and testbench

- Data-memory responder on the far side of the MemRead/MemWrite/MemtoReg control path from the instruction decoder.
- Accepts one load or store request per transaction from the MEM stage and holds the pipeline with a stall signal for a programmable latency.
- Performs RV32I byte, half and word accesses with lane steering and sign extension. Returns the load result with a one-cycle ready pulse.
- Owns the data-memory array; replaces the single-cycle combinational data memory.

---
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle RV32I data memory with byte/half/word lane steering.
// Optional DMEM_PERF_EN adds load/store/error event counters.
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        ready,
  output logic        err
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [15:0] err_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          f3_q, f3_d;
  logic                is_load_q, is_load_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         mem [DEPTH];

  logic                legal_f3, aligned, accept;
  logic [31:0]         word, load_val, merged;
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  always_comb begin
    legal_f3 = MemRead ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                       : (funct3 inside {3'b000, 3'b001, 3'b010});
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    accept = (MemRead ^ MemWrite) & legal_f3 & aligned;
  end

  // Lane steering works on the latched request so inputs may change once accepted.
  always_comb begin
    word     = mem[addr_q[ADDR_W+1:2]];
    sel_byte = word[{addr_q[1:0], 3'b000} +: 8];
    sel_half = word[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = word;
    endcase
    merged = word;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    is_load_d = is_load_q;
    rdata_d   = rdata_q;
    stall     = 1'b0;
    ready     = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d    = addr[ADDR_W+1:0];
          wdata_d   = wdata;
          f3_d      = funct3;
          is_load_d = MemRead;
          cnt_d     = 4'(LATENCY - 1);
          state_d   = (LATENCY == 1) ? DONE : WAIT;
          stall     = 1'b1;
        end else if (MemRead | MemWrite) begin
          err = 1'b1;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
        if (is_load_q) rdata_d = load_val;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      is_load_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      is_load_q <= is_load_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory has no reset; a reset before DONE drops the pending store.
  always_ff @(posedge clk) begin
    if (state_q == DONE && !is_load_q) mem[addr_q[ADDR_W+1:2]] <= merged;
  end

  assign rdata = rdata_q;

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count  <= 32'd0;
      store_count <= 32'd0;
      err_count   <= 16'd0;
    end else begin
      if (state_q == DONE) begin
        if (is_load_q) load_count  <= load_count + 32'd1;
        else           store_count <= store_count + 32'd1;
      end
      if (err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks against a byte-addressed memory model.
`default_nettype none

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, sel;
  logic [31:0] a, d;
  logic [2:0]  f3;

  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, ready0, ready1, err0, err1;
`ifdef DMEM_PERF_EN
  logic [31:0] ldc0, ldc1, stc0, stc1;
  logic [15:0] erc0, erc1;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd & ~sel), .MemWrite(wr & ~sel),
    .addr(a), .wdata(d), .funct3(f3),
    .rdata(rdata0), .stall(stall0), .ready(ready0), .err(err0)
`ifdef DMEM_PERF_EN
    , .load_count(ldc0), .store_count(stc0), .err_count(erc0)
`endif
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd & sel), .MemWrite(wr & sel),
    .addr(a), .wdata(d), .funct3(f3),
    .rdata(rdata1), .stall(stall1), .ready(ready1), .err(err1)
`ifdef DMEM_PERF_EN
    , .load_count(ldc1), .store_count(stc1), .err_count(erc1)
`endif
  );

  wire [31:0] o_rdata = sel ? rdata1 : rdata0;
  wire        o_stall = sel ? stall1 : stall0;
  wire        o_ready = sel ? ready1 : ready0;
  wire        o_err   = sel ? err1   : err0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ld = 0, n_st = 0, n_er = 0;

  logic [7:0]  mb   [2][1024];
  logic [31:0] rexp [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input bit r, input bit w, input logic [31:0] ad,
                                 input logic [2:0] f);
    int n;
    if (r == w) return 1'b0;
    if (r && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (w && f > 3'd2) return 1'b0;
    n = 1 << f[1:0];
    return (ad & 32'(n - 1)) == 32'd0;
  endfunction

  function automatic logic [31:0] m_load(input int s, input logic [31:0] ad, input logic [2:0] f);
    int          n;
    logic [31:0] v;
    logic [9:0]  ba;
    n = 1 << f[1:0];
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      ba = 10'(ad + 32'(i));
      v  = v | (32'(mb[s][ba]) << (8 * i));
    end
    if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input int s, input logic [31:0] ad, input logic [2:0] f,
                         input logic [31:0] data);
    int         n;
    logic [9:0] ba;
    n = 1 << f[1:0];
    for (int i = 0; i < n; i++) begin
      ba        = 10'(ad + 32'(i));
      mb[s][ba] = data[8*i +: 8];
    end
  endtask

  // One request held on the inputs from acceptance through the ready cycle.
  task automatic txn(input bit s, input bit r, input bit w, input logic [31:0] ad,
                     input logic [31:0] wd, input logic [2:0] f);
    int lat;
    lat = s ? 1 : 2;
    @(negedge clk);
    sel = s; rd = r; wr = w; a = ad; d = wd; f3 = f;
    #1;
    if (!r && !w) begin
      chk1("idle_stall", o_stall, 1'b0);
      chk1("idle_err", o_err, 1'b0);
    end else if (!m_legal(r, w, ad, f)) begin
      chk1("bad_err", o_err, 1'b1);
      chk1("bad_stall", o_stall, 1'b0);
      chk1("bad_ready", o_ready, 1'b0);
      @(negedge clk); #1;
      chk1("bad_err_persist", o_err, 1'b1);
      chk1("bad_ready2", o_ready, 1'b0);
      if (!s) n_er += 2;
    end else begin
      chk1("acc_stall", o_stall, 1'b1);
      chk1("acc_err", o_err, 1'b0);
      chk1("acc_ready", o_ready, 1'b0);
      for (int k = 1; k < lat; k++) begin
        @(negedge clk); #1;
        chk1("wait_stall", o_stall, 1'b1);
        chk1("wait_ready", o_ready, 1'b0);
      end
      @(negedge clk); #1;
      chk1("done_ready", o_ready, 1'b1);
      chk1("done_stall", o_stall, 1'b0);
      chk1("done_err", o_err, 1'b0);
      if (r) begin
        rexp[s] = m_load(s, ad, f);
        if (!s) n_ld++;
      end else begin
        m_store(s, ad, f, wd);
        if (!s) n_st++;
      end
    end
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    #1;
    chk1("post_ready", o_ready, 1'b0);
    chk1("post_stall", o_stall, 1'b0);
    chk1("post_err", o_err, 1'b0);
    chk("rdata", o_rdata, rexp[s]);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf;
    bit          rr, rw;
    int          kind;

    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; sel = 1'b0; a = 32'd0; d = 32'd0; f3 = 3'd0;
    rexp[0] = 32'd0; rexp[1] = 32'd0;
    #2;
    chk("rst_rdata", rdata0, 32'd0);
    chk1("rst_ready", ready0, 1'b0);
    chk1("rst_err", err0, 1'b0);
    chk1("rst_stall", stall0, 1'b0);
    chk("rst_rdata_l1", rdata1, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w < 32; w++) txn(1'b0, 1'b0, 1'b1, 32'(w * 4), $urandom, 3'd2);
    for (int w = 0; w < 4; w++)  txn(1'b1, 1'b0, 1'b1, 32'(w * 4), $urandom, 3'd2);

    txn(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
    txn(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
    chk("lw_deadbeef", rdata0, 32'hDEADBEEF);

    txn(1'b0, 1'b0, 1'b1, 32'h10, 32'h11223344, 3'd2);
    txn(1'b0, 1'b0, 1'b1, 32'h13, 32'h00000080, 3'd0);
    txn(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
    chk("sb_word", rdata0, 32'h80223344);
    txn(1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 3'd0);
    chk("lb_sext", rdata0, 32'hFFFFFF80);
    txn(1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 3'd4);
    chk("lbu_zext", rdata0, 32'h00000080);

    txn(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 3'd2);
    txn(1'b0, 1'b0, 1'b1, 32'h22, 32'h0000ABCD, 3'd1);
    txn(1'b0, 1'b1, 1'b0, 32'h22, 32'd0, 3'd5);
    chk("lhu", rdata0, 32'h0000ABCD);
    txn(1'b0, 1'b1, 1'b0, 32'h22, 32'd0, 3'd1);
    chk("lh", rdata0, 32'hFFFFABCD);
    txn(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 3'd5);
    chk("lhu_low_kept", rdata0, 32'h00005678);

    txn(1'b0, 1'b1, 1'b0, 32'h11, 32'd0, 3'd2);
    txn(1'b0, 1'b1, 1'b1, 32'h10, 32'h55555555, 3'd2);
    txn(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3'd3);
    txn(1'b0, 1'b0, 1'b1, 32'h10, 32'h66666666, 3'd4);
    txn(1'b0, 1'b0, 1'b1, 32'h21, 32'h77777777, 3'd1);
    txn(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
    chk("err_mem_kept", rdata0, 32'h80223344);

    txn(1'b0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 3'd2);
    txn(1'b0, 1'b1, 1'b0, 32'h000, 32'd0, 3'd2);
    chk("wrap", rdata0, 32'hCAFEF00D);

    txn(1'b1, 1'b0, 1'b1, 32'h8, 32'h5A5AA5A5, 3'd2);
    txn(1'b1, 1'b1, 1'b0, 32'h8, 32'd0, 3'd2);
    chk("lat1_lw", rdata1, 32'h5A5AA5A5);

    // Abandon a store while it waits, then confirm the old word survives.
    @(negedge clk);
    sel = 1'b0; wr = 1'b1; a = 32'h40; d = 32'hBADC0FFE; f3 = 3'd2;
    #1;
    chk1("mid_acc_stall", stall0, 1'b1);
    @(negedge clk); #1;
    chk1("mid_wait_stall", stall0, 1'b1);
    rst_n = 1'b0; wr = 1'b0;
    #1;
    chk1("mid_rst_ready", ready0, 1'b0);
    chk1("mid_rst_stall", stall0, 1'b0);
    chk("mid_rst_rdata", rdata0, 32'd0);
    rexp[0] = 32'd0; rexp[1] = 32'd0;
    n_ld = 0; n_st = 0; n_er = 0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 1'b1, 1'b0, 32'h40, 32'd0, 3'd2);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      rr   = (kind <= 4);
      rw   = (kind == 0) || (kind >= 5);
      rf   = 3'($urandom_range(0, 7));
      ra   = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 3) == 0) ra = ra | 32'($urandom_range(0, 3));
      txn(1'b0, rr, rw, ra, $urandom, rf);
    end

`ifdef DMEM_PERF_EN
    chk("load_count", ldc0, 32'(n_ld));
    chk("store_count", stc0, 32'(n_st));
    chk("err_count", {16'd0, erc0}, 32'(n_er));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
